encoder_input_conditioner: RTL and testbench

- Front-end stage for the rotary encoder: synchronises the raw enc_a, enc_b and enc_btn pins to clk.
- Debounces each input with an independent stable-count filter.
- Produces the debounced levels and single-cycle edge pulses consumed by the downstream encoder add/sub counter (enc_a_db, enc_b_db, enc_a_rise), plus a qualified step/direction pair and a button press pulse for the stopwatch control logic.

---
 rtl/encoder_input_conditioner.sv | 136 +++++++++++++
 tb/tb_encoder_input_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_input_conditioner
//  Description : Rotary encoder front end. Synchronises the raw A/B/button
//                pins, debounces each with a stable-count filter, and emits
//                edge pulses plus a step/direction pair, with startup
//                blanking of all pulses after reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_input_conditioner #(
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enc_btn,
  output logic enc_a_db,
  output logic enc_b_db,
  output logic enc_btn_db,
  output logic enc_a_rise,
  output logic enc_a_fall,
  output logic enc_btn_press,
  output logic enc_step,
  output logic enc_dir
);

  // Channel index: 0 = A, 1 = B, 2 = button.
  localparam int             c_nch       = 3;
  localparam logic [CNT_W-1:0] c_db_max  = CNT_W'(DB_CYCLES - 1);
  // One extra bit so DB_CYCLES+2 always fits even when DB_CYCLES is at the
  // top of the debounce counter range.
  localparam int             c_sw        = CNT_W + 1;
  localparam logic [c_sw-1:0] c_start_end = c_sw'(DB_CYCLES + 2);

  logic [c_nch-1:0] w_pin;
  logic [c_nch-1:0] r_meta;
  logic [c_nch-1:0] r_sync;
  logic [c_nch-1:0] w_db;
  logic [c_nch-1:0] w_upd;
  logic [c_sw-1:0]  r_start;
  logic             w_blank;
  logic             w_a_up;
  logic             w_a_down;
  logic             w_btn_up;
  logic             r_a_rise;
  logic             r_a_fall;
  logic             r_btn_press;
  logic             r_step;
  logic             r_dir;

  assign w_pin = {enc_btn, enc_b, enc_a};

  // Two-flop synchroniser for every raw pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_pin;
      r_sync <= r_meta;
    end
  end

  generate
    for (genvar g = 0; g < c_nch; g++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;

      // Level moves only after DB_CYCLES consecutive disagreeing samples;
      // any agreeing sample restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_sync[g] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_max) begin
          r_db  <= r_sync[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[g]  = r_db;
      assign w_upd[g] = (r_sync[g] != r_db) && (r_cnt == c_db_max);
    end
  endgenerate

  // Startup window counter; saturates once blanking is over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= '0;
    end else if (w_blank) begin
      r_start <= r_start + 1'b1;
    end
  end

  assign w_blank  = (r_start != c_start_end);
  assign w_a_up   = w_upd[0] && !w_db[0] && !w_blank;
  assign w_a_down = w_upd[0] &&  w_db[0] && !w_blank;
  assign w_btn_up = w_upd[2] && !w_db[2] && !w_blank;

  // Pulses land on the same edge as the level change; direction captures
  // the B level held before that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rise    <= 1'b0;
      r_a_fall    <= 1'b0;
      r_btn_press <= 1'b0;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
    end else begin
      r_a_rise    <= w_a_up;
      r_a_fall    <= w_a_down;
      r_btn_press <= w_btn_up;
      r_step      <= w_a_up;
      if (w_a_up) begin
        r_dir <= w_db[1];
      end
    end
  end

  assign enc_a_db      = w_db[0];
  assign enc_b_db      = w_db[1];
  assign enc_btn_db    = w_db[2];
  assign enc_a_rise    = r_a_rise;
  assign enc_a_fall    = r_a_fall;
  assign enc_btn_press = r_btn_press;
  assign enc_step      = r_step;
  assign enc_dir       = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_encoder_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_input_conditioner
//  Description : Self-checking bench for encoder_input_conditioner using a
//                sample-history reference model and random plus directed
//                pin activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_input_conditioner;

  localparam int DB    = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc_a = 1'b0, enc_b = 1'b0, enc_btn = 1'b0;
  logic enc_a_db, enc_b_db, enc_btn_db;
  logic enc_a_rise, enc_a_fall, enc_btn_press, enc_step, enc_dir;

  int checks = 0;
  int errors = 0;
  int n_rise = 0, n_fall = 0, n_press = 0, n_step = 0;

  always #5 clk = ~clk;

  encoder_input_conditioner #(.DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
    .enc_a_db(enc_a_db), .enc_b_db(enc_b_db), .enc_btn_db(enc_btn_db),
    .enc_a_rise(enc_a_rise), .enc_a_fall(enc_a_fall),
    .enc_btn_press(enc_btn_press), .enc_step(enc_step), .enc_dir(enc_dir)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: hist[ch][i] is the pin value sampled i edges ago.
  // A level flips once the samples that reached the filter over the last
  // DB edges (those taken 2..DB+1 edges ago) all disagree with it.
  bit hist [3][DB+2];
  bit m_db [3];
  bit chg  [3];
  bit pins [3];
  bit m_rise, m_fall, m_press, m_step, m_dir, blank, old_b, stable;
  int m_edges;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_db[c] = 0;
        for (int i = 0; i < DB + 2; i++) hist[c][i] = 0;
      end
      m_rise = 0; m_fall = 0; m_press = 0; m_step = 0; m_dir = 0;
      m_edges = 0;
    end else begin
      blank = (m_edges < DB + 2);
      if (blank) m_edges++;
      pins[0] = enc_a; pins[1] = enc_b; pins[2] = enc_btn;
      old_b = m_db[1];
      for (int c = 0; c < 3; c++) begin
        for (int i = DB + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = pins[c];
        stable = 1;
        for (int i = 2; i <= DB + 1; i++) if (hist[c][i] == m_db[c]) stable = 0;
        chg[c] = stable;
        if (stable) m_db[c] = ~m_db[c];
      end
      m_rise  = chg[0] &&  m_db[0] && !blank;
      m_fall  = chg[0] && !m_db[0] && !blank;
      m_press = chg[2] &&  m_db[2] && !blank;
      m_step  = m_rise;
      if (m_step) m_dir = old_b;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("a_db",    enc_a_db,      m_db[0]);
    check("b_db",    enc_b_db,      m_db[1]);
    check("btn_db",  enc_btn_db,    m_db[2]);
    check("a_rise",  enc_a_rise,    m_rise);
    check("a_fall",  enc_a_fall,    m_fall);
    check("press",   enc_btn_press, m_press);
    check("step",    enc_step,      m_step);
    check("dir",     enc_dir,       m_dir);
    if (enc_a_rise)    n_rise++;
    if (enc_a_fall)    n_fall++;
    if (enc_btn_press) n_press++;
    if (enc_step)      n_step++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins_set(input logic a, input logic b, input logic btn);
    enc_a = a; enc_b = b; enc_btn = btn;
  endtask

  int s0;

  initial begin
    // Reset state.
    cyc(3);
    #2 rst = 1'b0;
    cyc(1);
    check("rst_state", {enc_a_db, enc_b_db, enc_btn_db, enc_a_rise, enc_a_fall,
                        enc_btn_press, enc_step, enc_dir}, 0);

    // A raised and held with B low: one step, dir 0.
    cyc(18);
    s0 = n_step;
    enc_a = 1'b1;
    cyc(15);
    check("s1_steps", n_step - s0, 1);
    check("s1_dir", enc_dir, 0);
    enc_a = 1'b0;
    cyc(15);

    // B high, A pulsed for 40 cycles: step with dir 1, single fall.
    enc_b = 1'b1;
    cyc(10);
    s0 = n_step + n_fall * 100;
    enc_a = 1'b1;
    cyc(40);
    enc_a = 1'b0;
    cyc(15);
    check("s2_step_fall", n_step + n_fall * 100 - s0, 101);
    check("s2_dir", enc_dir, 1);
    check("s2_bdb", enc_b_db, 1);
    enc_b = 1'b0;
    cyc(15);

    // Glitches shorter than the filter never reach the level.
    s0 = n_rise + n_fall + n_step;
    for (int i = 0; i < 10; i++) begin
      enc_a = 1'b1; cyc(3);
      enc_a = 1'b0; cyc(3);
    end
    check("s3_pulses", n_rise + n_fall + n_step - s0, 0);
    check("s3_adb", enc_a_db, 0);
    cyc(10);

    // All pins high through reset release: levels settle, no pulses.
    #2 rst = 1'b1;
    pins_set(1, 1, 1);
    cyc(3);
    #2 rst = 1'b0;
    s0 = n_rise + n_step + n_press;
    cyc(DB + 2);
    check("s4_levels", {enc_a_db, enc_b_db, enc_btn_db}, 3'b111);
    cyc(10);
    check("s4_pulses", n_rise + n_step + n_press - s0, 0);
    check("s4_dir", enc_dir, 0);
    pins_set(0, 0, 0);
    cyc(15);

    // Establish dir=1, then raise A and B together: old B (0) is used.
    enc_b = 1'b1; cyc(10);
    enc_a = 1'b1; cyc(10);
    enc_a = 1'b0; cyc(10);
    enc_b = 1'b0; cyc(10);
    check("s5_pre_dir", enc_dir, 1);
    s0 = n_step;
    pins_set(1, 1, 0);
    cyc(12);
    check("s5_steps", n_step - s0, 1);
    check("s5_dir", enc_dir, 0);
    check("s5_levels", {enc_a_db, enc_b_db}, 2'b11);
    pins_set(0, 0, 0);
    cyc(15);

    // Reset mid-count with A high.
    enc_btn = 1'b1; cyc(12);
    enc_a = 1'b1;
    cyc(4);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_out", {enc_a_db, enc_b_db, enc_btn_db, enc_a_rise, enc_a_fall,
                         enc_btn_press, enc_step, enc_dir}, 0);
    cyc(2);
    #2 rst = 1'b0;
    s0 = n_rise + n_fall + n_step + n_press;
    cyc(DB + 2);
    check("s6_adb", enc_a_db, 1);
    cyc(10);
    check("s6_pulses", n_rise + n_fall + n_step + n_press - s0, 0);
    pins_set(0, 0, 0);
    cyc(15);

    // Random pin activity with occasional resets.
    for (int seg = 0; seg < 500; seg++) begin
      if ($urandom_range(0, 99) < 3) begin
        #2 rst = 1'b1;
        cyc($urandom_range(1, 3));
        #2 rst = 1'b0;
      end
      pins_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      cyc($urandom_range(1, 10));
    end
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
